// File: rtl/ram_stream_reader_if.sv
// Purpose: groups the RAM read port and the output valid/ready stream of
//          ram_stream_reader into one bundle.
// Signals: ram_addr/ram_we/ram_q - RAM macro port (reader drives address/we)
//          out_data/out_valid/out_ready - word stream towards the consumer
// Modports: master = reader side, slave = RAM + consumer side.
interface ram_stream_reader_if #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8
);
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_q;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output ram_addr, ram_we, out_data, out_valid,
      input  ram_q, out_ready
   );

   modport slave (
      input  ram_addr, ram_we, out_data, out_valid,
      output ram_q, out_ready
   );
endinterface

// File: rtl/ram_stream_reader.sv
// Purpose: reads a programmable (base, count, stride) sequence of words from a
//          synchronous-read RAM, streams each word out on valid/ready, keeps a
//          running checksum and pulses done at the end of the sequence.
// Ports:   clk, rst_n           - clock, async active-low reset
//          start, abort         - begin sequence (IDLE only) / abandon sequence
//          base_addr/count/stride - sequence parameters, latched on start
//          sum                  - running checksum of words read
//          busy, done           - not-idle flag, one-cycle completion pulse
//          bus (master)         - RAM read port and output stream
module ram_stream_reader #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8,
   parameter int unsigned SW = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [AW-1:0]            base_addr,
   input  logic [AW:0]              count,
   input  logic [AW-1:0]            stride,
   output logic [SW-1:0]            sum,
   output logic                     busy,
   output logic                     done,
   ram_stream_reader_if.master      bus
);

   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_LATCH = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e         state_q,  state_d;
   logic [AW-1:0]  addr_q,   addr_d;
   logic [AW-1:0]  stride_q, stride_d;
   logic [CW-1:0]  rem_q,    rem_d;
   logic [DW-1:0]  data_q,   data_d;
   logic           valid_q,  valid_d;
   logic [SW-1:0]  sum_q,    sum_d;
   logic           busy_q,   busy_d;
   logic           done_q,   done_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         rem_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         sum_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         rem_q    <= rem_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         sum_q    <= sum_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      rem_d    = rem_q;
      data_d   = data_q;
      valid_d  = valid_q;
      sum_d    = sum_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               rem_d    = count;
               stride_d = stride;
               sum_d    = '0;
               state_d  = (count == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            state_d = abort ? S_IDLE : S_LATCH;
         end
         S_LATCH: begin
            if (abort) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               data_d  = bus.ram_q;
               valid_d = 1'b1;
               sum_d   = sum_q + SW'(bus.ram_q);
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (abort) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else if (valid_q && bus.out_ready) begin
               valid_d = 1'b0;
               addr_d  = addr_q + stride_q;
               rem_d   = rem_q - CW'(1);
               state_d = (rem_q == CW'(1)) ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Flags are registered from the next state so they align with the state
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   assign bus.ram_addr  = addr_q;
   assign bus.ram_we    = 1'b0;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign sum           = sum_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Purpose: directed self-checking bench for ram_stream_reader with a
//          synchronous-read 16x8 RAM model attached to the read port.
module tb_ram_stream_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [3:0]  base_addr;
   logic [4:0]  count;
   logic [3:0]  stride;
   logic [19:0] sum;
   logic        busy;
   logic        done;
   logic [7:0]  mem [16];

   int n_vec;
   int n_err;
   int w;

   ram_stream_reader_if #(.AW(4), .DW(8)) bus ();

   ram_stream_reader #(.AW(4), .DW(8), .SW(20)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .count     (count),
      .stride    (stride),
      .sum       (sum),
      .busy      (busy),
      .done      (done),
      .bus       (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM model
   always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_seq(input logic [3:0] b, input logic [4:0] c, input logic [3:0] s);
      base_addr = b;
      count     = c;
      stride    = s;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Waits for out_valid, checks the word; returns cycles waited
   task automatic expect_word(input string tag, input logic [7:0] exp, output int waited);
      waited = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         waited++;
         if (bus.out_valid) break;
      end
      chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " data"}, 32'(bus.out_data), 32'(exp));
   endtask

   // Waits for done, checks the pulse, final sum and return to idle
   task automatic expect_done(input string tag, input logic [19:0] exp_sum);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " sum"}, 32'(sum), 32'(exp_sum));
      chk({tag, " busy in done"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, " done drop"}, 32'(done), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
      chk({tag, " sum hold"}, 32'(sum), 32'(exp_sum));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      base_addr = '0;
      count = '0;
      stride = '0;
      bus.out_ready = 1'b1;
      mem[0] = 8'd0;
      for (int i = 1; i <= 8; i++) mem[i] = 8'(i * i);
      for (int i = 9; i <= 15; i++) mem[i] = 8'(i - 8);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_data", 32'(bus.out_data), 32'd0);
      chk("rst sum", 32'(sum), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst ram_we", 32'(bus.ram_we), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic sequence with latency and cadence checks
      start_seq(4'd1, 5'd4, 4'd1);
      chk("lat busy", 32'(busy), 32'd1);
      chk("lat ram_addr", 32'(bus.ram_addr), 32'd1);
      chk("lat read valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("lat latch valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("lat hold valid", 32'(bus.out_valid), 32'd1);
      chk("seq1 w0", 32'(bus.out_data), 32'd1);
      expect_word("seq1 w1", 8'd4, w);
      chk("seq1 cadence", 32'(w), 32'd3);
      expect_word("seq1 w2", 8'd9, w);
      expect_word("seq1 w3", 8'd16, w);
      chk("seq1 ram_we", 32'(bus.ram_we), 32'd0);
      expect_done("seq1", 20'd30);

      // Address wrap-around
      start_seq(4'd14, 5'd4, 4'd1);
      expect_word("wrap w0", 8'd6, w);
      expect_word("wrap w1", 8'd7, w);
      expect_word("wrap w2", 8'd0, w);
      expect_word("wrap w3", 8'd1, w);
      expect_done("wrap", 20'd14);

      // Stride 3
      start_seq(4'd5, 5'd3, 4'd3);
      expect_word("stride w0", 8'd25, w);
      expect_word("stride w1", 8'd64, w);
      expect_word("stride w2", 8'd3, w);
      expect_done("stride", 20'd92);

      // Backpressure on the first word
      bus.out_ready = 1'b0;
      start_seq(4'd2, 5'd2, 4'd1);
      expect_word("bp w0", 8'd4, w);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         chk("bp hold valid", 32'(bus.out_valid), 32'd1);
         chk("bp hold data", 32'(bus.out_data), 32'd4);
      end
      chk("bp hold sum", 32'(sum), 32'd4);
      bus.out_ready = 1'b1;
      expect_word("bp w1", 8'd9, w);
      expect_done("bp", 20'd13);

      // Zero-length sequence
      start_seq(4'd3, 5'd0, 4'd1);
      chk("cnt0 done", 32'(done), 32'd1);
      chk("cnt0 valid", 32'(bus.out_valid), 32'd0);
      chk("cnt0 sum", 32'(sum), 32'd0);
      @(negedge clk);
      chk("cnt0 done drop", 32'(done), 32'd0);
      chk("cnt0 idle", 32'(busy), 32'd0);

      // start while busy is ignored
      start_seq(4'd1, 5'd2, 4'd1);
      expect_word("busy w0", 8'd1, w);
      base_addr = 4'd8;
      count     = 5'd16;
      stride    = 4'd0;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      expect_word("busy w1", 8'd4, w);
      expect_done("busy", 20'd5);
      @(negedge clk);
      chk("busy no restart", 32'(busy), 32'd0);

      // Full depth, stride 0
      start_seq(4'd8, 5'd16, 4'd0);
      for (int i = 0; i < 16; i++) expect_word("full w", 8'd64, w);
      expect_done("full", 20'd1024);

      // Asynchronous reset while holding a word
      bus.out_ready = 1'b0;
      start_seq(4'd1, 5'd4, 4'd1);
      expect_word("arst w0", 8'd1, w);
      #2 rst_n = 1'b0;
      #1;
      chk("arst valid", 32'(bus.out_valid), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst sum", 32'(sum), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Abort in HOLD, then a fresh sequence
      start_seq(4'd1, 5'd4, 4'd1);
      expect_word("abort w0", 8'd1, w);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort valid", 32'(bus.out_valid), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort sum", 32'(sum), 32'd1);
      @(negedge clk);
      chk("abort no done", 32'(done), 32'd0);
      bus.out_ready = 1'b1;
      start_seq(4'd5, 5'd3, 4'd3);
      expect_word("post w0", 8'd25, w);
      expect_word("post w1", 8'd64, w);
      expect_word("post w2", 8'd3, w);
      expect_done("post", 20'd92);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
